bure_stage_if: RTL and testbench

Instruction fetch stage of the BureCore pipeline. It holds the program counter and issues sequential word fetches to instruction memory over a request/grant/response handshake. Responses are buffered in a small in-order FIFO, and the stage presents one instruction per cycle to the decode stage through `bure_if_interface`. It accepts a stall from the hazard logic and a redirect from the execute stage; on a redirect it flushes all buffered and in-flight instructions.

---
 rtl/bure_pkg.sv | 14 +
 rtl/bure_stage_if_if.sv | 16 +
 rtl/bure_sync_fifo.sv | 60 ++++++
 rtl/bure_stage_if.sv | 127 ++++++++++++
 tb/tb_bure_stage_if.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bure_pkg.sv
// Shared BureCore definitions: default widths, reset PC and the fetch buffer entry.
package bure_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned INSTR_W     = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [ADDR_W-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/bure_stage_if_if.sv
// Fetch-to-decode link: one registered instruction with its address and a valid flag.
interface bure_if_interface
   import bure_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = ADDR_W,
   parameter int unsigned INSTR_WIDTH = INSTR_W
);

   logic                   instr_valid;
   logic [INSTR_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0]  instr_addr;

   modport master (output instr_valid, output instr, output instr_addr);
   modport slave  (input  instr_valid, input  instr, input  instr_addr);

endinterface

// File: rtl/bure_sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count; flush wins over push and pop.
module bure_sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_count  = r_count;
   assign o_rdata  = r_mem[r_rdPtr];
   assign w_doPush = i_push && !o_full && !i_flush;
   assign w_doPop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
   end

endmodule

// File: rtl/bure_stage_if.sv
// BureCore instruction fetch: PC, in-order request/grant/response fetch, response buffer feeding decode.
module bure_stage_if
   import bure_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = ADDR_W,
   parameter int unsigned           INSTR_WIDTH = INSTR_W,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = RESET_ADDR_DEFAULT,
   parameter int unsigned           FIFO_DEPTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   output logic                   o_imem_req,
   output logic [ADDR_WIDTH-1:0]  o_imem_addr,
   input  logic                   i_imem_gnt,
   input  logic                   i_imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
   input  logic                   i_stall,
   input  logic                   i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  i_redirect_addr,
   bure_if_interface.master       if_if
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

   if ((INSTR_WIDTH > DATA_WIDTH) || (ADDR_WIDTH != ADDR_W) || (INSTR_WIDTH != INSTR_W)) begin : g_badWidths
      $error("bure_stage_if: widths must match fetch_entry_t and fit the datapath");
   end

   logic [ADDR_WIDTH-1:0]  r_pc;
   logic [ADDR_WIDTH-1:0]  r_rspAddr;
   logic [CW-1:0]          r_outstanding;
   logic [CW-1:0]          r_kill;
   logic                   r_instrValid;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0]  r_instrAddr;

   logic [ADDR_WIDTH-1:0]  w_redirectPc;
   logic [CW:0]            w_inUse;
   logic                   w_fire;
   logic [CW-1:0]          w_rvalidCnt;
   logic                   w_keepRsp;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_fifoEmpty;
   logic                   w_fifoFull;
   logic [CW-1:0]          w_fifoCount;
   fetch_entry_t           w_pushEntry;
   fetch_entry_t           w_headEntry;

   assign w_redirectPc = i_redirect_addr & ~(ADDR_WIDTH'(INSTR_BYTES - 1));

   // Credit rule: every in-flight fetch owns a buffer slot, so a push can never overflow.
   assign w_inUse     = {1'b0, r_outstanding} + {1'b0, w_fifoCount};
   assign o_imem_req  = !i_redirect_valid && (w_inUse < (CW+1)'(FIFO_DEPTH));
   assign o_imem_addr = r_pc;
   assign w_fire      = o_imem_req && i_imem_gnt;
   assign w_rvalidCnt = CW'(i_imem_rvalid);
   assign w_keepRsp   = i_imem_rvalid && (r_kill == '0);
   assign w_push      = w_keepRsp && !i_redirect_valid;
   assign w_pop       = !i_redirect_valid && !i_stall && !w_fifoEmpty;
   assign w_pushEntry = {r_rspAddr, i_imem_rdata};

   bure_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_rspFifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (w_push),
      .i_wdata (w_pushEntry),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .o_rdata (w_headEntry),
      .o_count (w_fifoCount),
      .o_empty (w_fifoEmpty),
      .o_full  (w_fifoFull)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pc          <= RESET_ADDR;
         r_rspAddr     <= RESET_ADDR;
         r_outstanding <= '0;
         r_kill        <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_fire) - w_rvalidCnt;
         if (i_redirect_valid) begin
            r_pc      <= w_redirectPc;
            r_rspAddr <= w_redirectPc;
            r_kill    <= r_outstanding - w_rvalidCnt;
         end else begin
            if (w_fire) r_pc <= r_pc + STEP;
            if (w_keepRsp) r_rspAddr <= r_rspAddr + STEP;
            else if (i_imem_rvalid) r_kill <= r_kill - 1'b1;
         end
      end
   end

   // Output register holds under stall; a redirect always invalidates it.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_instrValid <= 1'b0;
         r_instr      <= '0;
         r_instrAddr  <= '0;
      end else if (i_redirect_valid) begin
         r_instrValid <= 1'b0;
      end else if (!i_stall) begin
         r_instrValid <= !w_fifoEmpty;
         if (!w_fifoEmpty) begin
            r_instr     <= w_headEntry.instr;
            r_instrAddr <= w_headEntry.addr;
         end
      end
   end

   assign if_if.instr_valid = r_instrValid;
   assign if_if.instr       = r_instr;
   assign if_if.instr_addr  = r_instrAddr;

   a_rvalidHasOwner: assert property (@(posedge i_clk) disable iff (!i_rstn)
      i_imem_rvalid |-> (r_outstanding != '0));
   a_pushHasRoom: assert property (@(posedge i_clk) disable iff (!i_rstn)
      w_push |-> !w_fifoFull);

endmodule

// File: tb/tb_bure_stage_if.sv
// Bench for bure_stage_if: queue-based fetch model plus an in-order memory with random grant/latency.
module tb_bure_stage_if;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_stall;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_addr;

   bure_if_interface ifBus ();

   bure_stage_if dut (
      .i_clk            (i_clk),
      .i_rstn           (i_rstn),
      .o_imem_req       (o_imem_req),
      .o_imem_addr      (o_imem_addr),
      .i_imem_gnt       (i_imem_gnt),
      .i_imem_rvalid    (i_imem_rvalid),
      .i_imem_rdata     (i_imem_rdata),
      .i_stall          (i_stall),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_addr  (i_redirect_addr),
      .if_if            (ifBus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { logic [31:0] addr; int due; bit killed; } pendT;
   typedef struct { logic [31:0] addr; logic [31:0] instr; } bufT;

   pendT        pendQ[$];
   bufT         bufQ[$];
   logic [31:0] mPc;
   logic        mValid;
   logic [31:0] mAddr;
   logic [31:0] mInstr;
   int          lastDue;
   int          cyc;
   bit          nopMode;
   int          testCount;
   int          failCount;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (nopMode) return 32'h0000_0013;
      return {addr[15:0] ^ 16'hC3A5, addr[31:16] + 16'h1234};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      pendQ.delete();
      bufQ.delete();
      mPc     = 32'h0;
      mValid  = 1'b0;
      mAddr   = 32'h0;
      mInstr  = 32'h0;
      lastDue = -100;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check request, advance the model.
   task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] raddr,
                                input bit gnt, input int extraLat);
      bit   rv;
      bit   expReq;
      pendT p;
      bufT  e;
      int   due;
      checkOutput("instr_valid", ifBus.instr_valid, mValid);
      if (mValid) begin
         checkOutput("instr_addr", ifBus.instr_addr, mAddr);
         checkOutput("instr", ifBus.instr, mInstr);
      end
      rv = (pendQ.size() > 0) && (pendQ[0].due <= cyc);
      i_stall          = stall;
      i_redirect_valid = redir;
      i_redirect_addr  = raddr;
      i_imem_gnt       = gnt;
      i_imem_rvalid    = rv;
      i_imem_rdata     = rv ? memWord(pendQ[0].addr) : 32'h0;
      #1;
      expReq = !redir && ((pendQ.size() + bufQ.size()) < 4);
      checkOutput("imem_req", o_imem_req, expReq);
      if (expReq) checkOutput("imem_addr", o_imem_addr, mPc);
      if (redir) begin
         mValid = 1'b0;
      end else if (!stall) begin
         if (bufQ.size() > 0) begin
            e      = bufQ.pop_front();
            mValid = 1'b1;
            mAddr  = e.addr;
            mInstr = e.instr;
         end else begin
            mValid = 1'b0;
         end
      end
      if (rv) begin
         p = pendQ.pop_front();
         if (!redir && !p.killed) bufQ.push_back('{p.addr, i_imem_rdata});
      end
      if (redir) begin
         bufQ.delete();
         foreach (pendQ[k]) pendQ[k].killed = 1'b1;
         mPc = raddr & ~32'h3;
      end else if (expReq && gnt) begin
         due = cyc + 1 + extraLat;
         if (due <= lastDue) due = lastDue + 1;
         pendQ.push_back('{mPc, due, 1'b0});
         lastDue = due;
         mPc     = mPc + 32'd4;
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic waitForValid(input string tag, input logic [31:0] expAddr);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (ifBus.instr_valid === 1'b1) seen = 1'b1;
         else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
      end
      checkOutput({tag, "_seen"}, seen, 1'b1);
      if (seen) checkOutput({tag, "_addr"}, ifBus.instr_addr, expAddr);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      testCount        = 0;
      failCount        = 0;
      cyc              = 0;
      nopMode          = 1'b1;
      i_rstn           = 1'b0;
      i_imem_gnt       = 1'b0;
      i_imem_rvalid    = 1'b0;
      i_imem_rdata     = 32'h0;
      i_stall          = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_addr  = 32'h0;
      modelReset();
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("rst_valid", ifBus.instr_valid, 1'b0);
      checkOutput("rst_instr", ifBus.instr, 32'h0);
      checkOutput("rst_iaddr", ifBus.instr_addr, 32'h0);
      checkOutput("rst_pc", o_imem_addr, 32'h0);
      i_rstn = 1'b1;

      // NOP stream from a one-cycle memory: first instruction in the 4th cycle after release.
      repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("nop_valid", ifBus.instr_valid, 1'b1);
         checkOutput("nop_addr", ifBus.instr_addr, 32'(i * 4));
         checkOutput("nop_instr", ifBus.instr, 32'h0000_0013);
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
      end
      nopMode = 1'b0;
      repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);

      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 0);
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);

      repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1, 0);
      waitForValid("redir100", 32'h0000_0100);
      repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);

      applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1, 0);
      waitForValid("redir103", 32'h0000_0100);

      repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 0);
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
                       $urandom_range(0, 9) < 7, $urandom_range(0, 2));
      end

      // Fill the buffer under stall with slow responses, then reset mid-operation.
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 0);
      repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 2);
      i_rstn           = 1'b0;
      i_imem_gnt       = 1'b0;
      i_imem_rvalid    = 1'b0;
      i_stall          = 1'b0;
      i_redirect_valid = 1'b0;
      #1;
      checkOutput("midrst_valid", ifBus.instr_valid, 1'b0);
      checkOutput("midrst_instr", ifBus.instr, 32'h0);
      checkOutput("midrst_iaddr", ifBus.instr_addr, 32'h0);
      checkOutput("midrst_pc", o_imem_addr, 32'h0);
      modelReset();
      @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0);
      waitForValid("postrst", mAddr);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
